fifo_stream_adapter: RTL and testbench

- Downstream read-side stage for the team's synchronous FIFO. Converts the FIFO's read-strobe interface (1-cycle registered read latency, empty flag) into a valid/ready stream.
- Prefetches words into a small internal skid buffer so a consumer gets 1 word/cycle with no combinational path from i_ready to the FIFO read strobe.
- Sits between fifo_generic and any stream consumer: packetiser, UART TX, DMA sink.

---
 rtl/fifo_stream_adapter.sv | 103 ++++++++++
 tb/tb_fifo_stream_adapter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_adapter.sv
// Read-side adapter that turns a FIFO read-strobe interface into a valid/ready stream via a prefetching skid buffer.
// Build option FIFO_STREAM_ADAPTER_STATS_EN adds saturating beat/stall counters; otherwise those ports read 0.
module fifo_stream_adapter #(
  parameter int DataWidth = 32,
  parameter int BufDepth  = 3
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  output logic                 o_fifo_read,
  input  logic [DataWidth-1:0] i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DataWidth-1:0] o_data,
  output logic [31:0]          o_beat_count,
  output logic [31:0]          o_stall_count
);

  localparam int IdxW = $clog2(BufDepth);
  localparam int CntW = $clog2(BufDepth + 1);
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(BufDepth);

  logic [DataWidth-1:0] buf_mem [BufDepth];
  logic [IdxW-1:0]      rd_idx;
  logic [IdxW-1:0]      wr_idx;
  logic [CntW-1:0]      count;
  logic                 inflight;
  logic [CntW:0]        occupancy;
  logic                 capture;
  logic                 pop;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(BufDepth - 1)) ? '0 : idx + IdxW'(1);
  endfunction

  // Reservations count the word still in flight so the buffer can never overflow;
  // the strobe depends only on registered state, never on i_ready.
  assign occupancy   = {1'b0, count} + (CntW + 1)'(inflight);
  assign o_fifo_read = i_rst_n && !i_fifo_empty && !i_flush && (occupancy < DepthLim);

  assign capture = inflight;
  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready;
  assign o_data  = buf_mem[rd_idx];

  // Stage boundary: read strobe -> in-flight flag -> buffer capture
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_idx   <= '0;
      wr_idx   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else if (i_flush) begin
      rd_idx   <= '0;
      wr_idx   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= o_fifo_read;
      if (capture) wr_idx <= wrap_inc(wr_idx);
      if (pop)     rd_idx <= wrap_inc(rd_idx);
      count <= count + CntW'(capture) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BufDepth; i++) buf_mem[i] <= '0;
    end else if (capture && !i_flush) begin
      buf_mem[wr_idx] <= i_fifo_data;
    end
  end

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
  logic [31:0] beat_count;
  logic [31:0] stall_count;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else if (i_flush) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      if (pop)                beat_count  <= sat_inc(beat_count);
      if (o_valid && !i_ready) stall_count <= sat_inc(stall_count);
    end
  end

  assign o_beat_count  = beat_count;
  assign o_stall_count = stall_count;
`else
  assign o_beat_count  = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: behavioural upstream FIFO, scoreboard on stream beats, vector table plus corner sequences.
module tb_fifo_stream_adapter;
  localparam int DW = 32;
  localparam int BD = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          fifo_read;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [31:0]   beat_count;
  logic [31:0]   stall_count;

  always #5 clk = ~clk;

  fifo_stream_adapter #(.DataWidth(DW), .BufDepth(BD)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .o_fifo_read  (fifo_read),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_data       (data),
    .o_beat_count (beat_count),
    .o_stall_count(stall_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Upstream FIFO model: one-cycle registered read latency, reads gated when empty
  logic [DW-1:0] mem [4096];
  int wp = 0;
  int rp = 0;
  logic [DW-1:0] exp_q[$];

  assign fifo_empty = (rp == wp);

  always @(posedge clk) begin
    if (fifo_read && (rp != wp)) begin
      fifo_data <= mem[rp[11:0]];
      rp <= rp + 1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wp[11:0]] = w;
    wp++;
    exp_q.push_back(w);
  endtask

  // Outstanding words (buffered + in flight) tracked from the interface alone
  int occ   = 0;
  int reads = 0;
  always @(posedge clk) begin
    if (!rst_n || flush) occ <= 0;
    else occ <= occ + (fifo_read ? 1 : 0) - ((valid && ready) ? 1 : 0);
    if (fifo_read) reads <= reads + 1;
  end

  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic          pf = 1'b0;
  logic [DW-1:0] pdata = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready && !flush) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
        else chk("beat_data", data, exp_q.pop_front());
      end
      if (pv && !pr && !pf) begin
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_data", data, pdata);
      end
      chk("occupancy_le_depth", 32'(occ <= BD), 32'd1);
    end
    pv    <= valid && rst_n;
    pr    <= ready;
    pf    <= flush;
    pdata <= data;
  end

  typedef struct {
    logic          rdy;
    logic          exp_read;
    logic          exp_valid;
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  task automatic wait_drain(input string name, input int lim);
    int n = 0;
    while ((exp_q.size() != 0 || valid) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < lim), 32'd1);
  endtask

  initial begin
    int first, last, nb, r0, drop, n, pushed, cyc;
    logic [DW-1:0] w0, w3;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA2};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA3};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    rst_n = 1'b0;
    flush = 1'b0;
    ready = 1'b1;
    push(32'hA1);
    push(32'hA2);
    push(32'hA3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_read", 32'(fifo_read), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_beats", beat_count, 32'd0);
    chk("rst_stalls", stall_count, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset release with three words waiting
    for (int i = 0; i < 6; i++) begin
      ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("t1_read[%0d]", i), 32'(fifo_read), 32'(vecs[i].exp_read));
      chk($sformatf("t1_valid[%0d]", i), 32'(valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data) chk($sformatf("t1_data[%0d]", i), data, vecs[i].exp_data);
    end

    // Sustained throughput
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) push(32'h2000_0000 + 32'(k));
    first = -1; last = -1; nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) begin
        nb++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("t2_latency", 32'(first), 32'd2);
    chk("t2_beats", 32'(nb), 32'd16);
    chk("t2_consecutive", 32'(last - first + 1), 32'd16);

    // Backpressure: buffer fills, reads stop, head word holds
    @(posedge clk);
    #1 ready = 1'b0;
    r0 = reads;
    w0 = 32'h3000_0000;
    for (int k = 0; k < 8; k++) push(w0 + 32'(k));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t3_reads", 32'(reads - r0), 32'd3);
    chk("t3_read_stopped", 32'(fifo_read), 32'd0);
    chk("t3_valid", 32'(valid), 32'd1);
    chk("t3_head", data, w0);
    @(posedge clk);
    #1 ready = 1'b1;
    wait_drain("t3_drain", 200);

    // Flush with count=2 and one read in flight
    @(posedge clk);
    #1 ready = 1'b0;
    w3 = 32'h4000_0003;
    for (int k = 0; k < 6; k++) push(32'h4000_0000 + 32'(k));
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("t4_read_in_flush", 32'(fifo_read), 32'd0);
    chk("t4_valid_before", 32'(valid), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    drop = exp_q.size() - (wp - rp);
    chk("t4_dropped", 32'(drop), 32'd3);
    for (int k = 0; k < drop; k++) void'(exp_q.pop_front());
    @(negedge clk);
    chk("t4_valid_after", 32'(valid), 32'd0);
    chk("t4_beats_clr", beat_count, 32'd0);
    chk("t4_stalls_clr", stall_count, 32'd0);
    @(posedge clk);
    #1 ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 20);
    chk("t4_next_word", data, w3);
    wait_drain("t4_drain", 200);

    // Random traffic and random backpressure
    pushed = 0;
    cyc = 0;
    while ((pushed < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      @(posedge clk);
      #1;
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push($urandom);
        pushed++;
      end
      ready = ($urandom_range(0, 1) == 1);
      cyc++;
    end
    chk("t5_complete", 32'(cyc < 20000), 32'd1);
    ready = 1'b1;
    wait_drain("t5_drain", 100);

    // Statistics: 10 beats and 4 stall cycles
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("t6_beats_clr", beat_count, 32'd0);
    chk("t6_stalls_clr", stall_count, 32'd0);
    @(posedge clk);
    #1 ready = 1'b0;
    for (int k = 0; k < 10; k++) push(32'h6000_0000 + 32'(k));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 20);
    chk("t6_valid_seen", 32'(valid), 32'd1);
    repeat (4) @(posedge clk);
    #1 ready = 1'b1;
    wait_drain("t6_drain", 200);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    chk("t6_beats", beat_count, 32'd10);
    chk("t6_stalls", stall_count, 32'd4);
`else
    chk("t6_beats", beat_count, 32'd0);
    chk("t6_stalls", stall_count, 32'd0);
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
